// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared state encodings and constants for the core memory bus adapter
package mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
   localparam logic [1:0]  WORD_ALIGN_MASK  = 2'b11;

   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_bus_adapter_if.sv
// rtl/mem_bus_adapter_if.sv - external word-memory bus: req/gnt request phase plus rvalid response
interface mem_bus_adapter_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();

   logic          bus_req;
   logic          bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic          bus_gnt;
   logic          bus_rvalid;
   logic [DW-1:0] bus_rdata;

   modport master (
      output bus_req,
      output bus_we,
      output bus_addr,
      output bus_wdata,
      input  bus_gnt,
      input  bus_rvalid,
      input  bus_rdata
   );

   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_addr,
      input  bus_wdata,
      output bus_gnt,
      output bus_rvalid,
      output bus_rdata
   );

endinterface

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - access watchdog; expired is high during the last allowed REQ/WAIT cycle
module mem_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_adapter.sv
// rtl/mem_bus_adapter.sv - bridges the multi-cycle core memory port to a req/gnt + rvalid word bus,
// stalling the core until the access completes and registering the returned data.
module mem_bus_adapter
   import mem_bus_pkg::*;
#(
   parameter int            AW       = 32,
   parameter int            DW       = 32,
   parameter int            TIMEOUT  = 16,
   parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          core_done,
   output logic          core_err,
   output logic          stall,
   mem_bus_adapter_if.master bus
);

   state_e        state_q, state_d;
   logic          bus_req_q, bus_req_d;
   logic          bus_we_q, bus_we_d;
   logic [AW-1:0] bus_addr_q, bus_addr_d;
   logic [DW-1:0] bus_wdata_q, bus_wdata_d;
   logic [DW-1:0] core_rdata_q, core_rdata_d;
   logic          core_done_q, core_done_d;
   logic          core_err_q, core_err_d;
   logic          stall_q, stall_d;

   logic          tmr_clear;
   logic          tmr_en;
   logic          tmr_expired;

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d      = state_q;
      bus_req_d    = bus_req_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      core_rdata_d = core_rdata_q;
      core_done_d  = 1'b0;
      core_err_d   = 1'b0;
      stall_d      = stall_q;
      tmr_clear    = 1'b0;
      tmr_en       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (core_req) begin
               if (is_word_aligned(core_addr[1:0])) begin
                  bus_we_d    = core_we;
                  bus_addr_d  = core_addr;
                  bus_wdata_d = core_wdata;
                  bus_req_d   = 1'b1;
                  stall_d     = 1'b1;
                  tmr_clear   = 1'b1;
                  state_d     = ST_REQ;
               end else begin
                  // Misaligned: complete immediately with an error, never touch the bus.
                  core_done_d  = 1'b1;
                  core_err_d   = 1'b1;
                  core_rdata_d = ERR_DATA;
                  state_d      = ST_DONE;
               end
            end
         end

         ST_REQ: begin
            tmr_en = 1'b1;
            if (bus_gnt_rvalid()) begin
               bus_req_d   = 1'b0;
               stall_d     = 1'b0;
               core_done_d = 1'b1;
               if (!bus_we_q) begin
                  core_rdata_d = bus.bus_rdata;
               end
               state_d = ST_DONE;
            end else if (tmr_expired) begin
               bus_req_d    = 1'b0;
               stall_d      = 1'b0;
               core_done_d  = 1'b1;
               core_err_d   = 1'b1;
               core_rdata_d = ERR_DATA;
               state_d      = ST_DONE;
            end else if (bus.bus_gnt) begin
               bus_req_d = 1'b0;
               state_d   = ST_WAIT;
            end
         end

         ST_WAIT: begin
            tmr_en = 1'b1;
            // A response in the expiry cycle still counts as a good completion.
            if (bus.bus_rvalid) begin
               stall_d     = 1'b0;
               core_done_d = 1'b1;
               if (!bus_we_q) begin
                  core_rdata_d = bus.bus_rdata;
               end
               state_d = ST_DONE;
            end else if (tmr_expired) begin
               stall_d      = 1'b0;
               core_done_d  = 1'b1;
               core_err_d   = 1'b1;
               core_rdata_d = ERR_DATA;
               state_d      = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   function automatic logic bus_gnt_rvalid();
      return bus.bus_gnt && bus.bus_rvalid;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         core_rdata_q <= '0;
         core_done_q  <= 1'b0;
         core_err_q   <= 1'b0;
         stall_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         bus_req_q    <= bus_req_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         core_rdata_q <= core_rdata_d;
         core_done_q  <= core_done_d;
         core_err_q   <= core_err_d;
         stall_q      <= stall_d;
      end
   end

   assign core_rdata    = core_rdata_q;
   assign core_done     = core_done_q;
   assign core_err      = core_err_q;
   assign stall         = stall_q;
   assign bus.bus_req   = bus_req_q;
   assign bus.bus_we    = bus_we_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// tb/tb_mem_bus_adapter.sv - randomized and directed self-checking bench for mem_bus_adapter
module tb_mem_bus_adapter;
   import mem_bus_pkg::*;

   localparam int          AW       = 32;
   localparam int          DW       = 32;
   localparam int          TIMEOUT  = 16;
   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          core_req = 1'b0;
   logic          core_we = 1'b0;
   logic [AW-1:0] core_addr = '0;
   logic [DW-1:0] core_wdata = '0;
   logic [DW-1:0] core_rdata;
   logic          core_done;
   logic          core_err;
   logic          stall;

   mem_bus_adapter_if #(.AW(AW), .DW(DW)) bus_if ();

   mem_bus_adapter #(
      .AW       (AW),
      .DW       (DW),
      .TIMEOUT  (TIMEOUT),
      .ERR_DATA (ERR_WORD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_done  (core_done),
      .core_err   (core_err),
      .stall      (stall),
      .bus        (bus_if)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [31:0] model_rdata = '0;

   always @(posedge clk) begin
      assert (reset || !(core_req && stall))
         else $error("protocol violation: core_req while stall");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // kg: REQ/WAIT cycle index (1 = first bus_req cycle) carrying bus_gnt.
   // kr: cycle index carrying the real bus_rvalid (kr >= kg).
   task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int kg, input int kr, input logic [31:0] rdata,
                             input bit stray, input string tag);
      logic [31:0] a;
      bit          aligned;
      int          exp_done_k;
      bit          exp_err;
      logic [31:0] exp_rd;
      int          exp_req;
      int          done_k = 0;
      int          req_cycles = 0;
      bit          bus_bad = 0;
      bit          err_bad = 0;
      bit          stall_bad = 0;
      bit          post_done = 0;
      bit          post_hold_bad = 0;
      logic        got_err = 1'b0;
      logic [31:0] got_rd = '0;

      a = addr;
      aligned = (a[1:0] == 2'b00);
      if (!aligned) begin
         exp_done_k = 1; exp_err = 1'b1; exp_rd = ERR_WORD; exp_req = 0;
      end else if (kr <= TIMEOUT) begin
         exp_done_k = kr + 1; exp_err = 1'b0; exp_rd = we ? model_rdata : rdata; exp_req = kg;
      end else begin
         exp_done_k = TIMEOUT + 1; exp_err = 1'b1; exp_rd = ERR_WORD;
         exp_req = (kg < TIMEOUT) ? kg : TIMEOUT;
      end

      @(negedge clk);
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
      for (int k = 1; k <= TIMEOUT + 4 && done_k == 0; k++) begin
         @(negedge clk);
         core_req = 1'b0;
         core_addr = $urandom;
         core_wdata = $urandom;
         if (bus_if.bus_req) begin
            req_cycles++;
            if (bus_if.bus_addr !== addr || bus_if.bus_we !== we || bus_if.bus_wdata !== wdata)
               bus_bad = 1;
         end
         if (core_done) begin
            done_k = k; got_err = core_err; got_rd = core_rdata;
         end
         if (!core_done && core_err) err_bad = 1;
         if (stall !== (aligned && k < exp_done_k)) stall_bad = 1;
         bus_if.bus_gnt    = aligned && (k == kg);
         bus_if.bus_rvalid = aligned && ((k == kr) || (stray && k < kg && $urandom_range(0, 1) == 1));
         bus_if.bus_rdata  = (k == kr) ? rdata : $urandom;
      end
      for (int p = 0; p < 2; p++) begin
         @(negedge clk);
         if (core_done || core_err) post_done = 1;
         if (core_rdata !== exp_rd) post_hold_bad = 1;
         bus_if.bus_gnt    = ($urandom_range(0, 1) == 1);
         bus_if.bus_rvalid = 1'b1;
         bus_if.bus_rdata  = $urandom;
      end
      bus_if.bus_gnt = 1'b0;
      bus_if.bus_rvalid = 1'b0;

      check_eq({tag, ".done_cycle"}, 64'(done_k), 64'(exp_done_k));
      check_eq({tag, ".err"}, 64'(got_err), 64'(exp_err));
      check_eq({tag, ".rdata"}, 64'(got_rd), 64'(exp_rd));
      check_eq({tag, ".req_cycles"}, 64'(req_cycles), 64'(exp_req));
      check_eq({tag, ".bus_stable"}, 64'(bus_bad), 64'd0);
      check_eq({tag, ".stall"}, 64'(stall_bad), 64'd0);
      check_eq({tag, ".err_wo_done"}, 64'(err_bad), 64'd0);
      check_eq({tag, ".stale_resp"}, 64'(post_done), 64'd0);
      check_eq({tag, ".rdata_held"}, 64'(post_hold_bad), 64'd0);
      model_rdata = exp_rd;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, ".bus_req"}, 64'(bus_if.bus_req), 64'd0);
      check_eq({tag, ".stall"}, 64'(stall), 64'd0);
      check_eq({tag, ".done"}, 64'(core_done), 64'd0);
      check_eq({tag, ".err"}, 64'(core_err), 64'd0);
      check_eq({tag, ".rdata"}, 64'(core_rdata), 64'd0);
      check_eq({tag, ".bus_addr"}, 64'(bus_if.bus_addr), 64'd0);
      check_eq({tag, ".bus_wdata"}, 64'(bus_if.bus_wdata), 64'd0);
      check_eq({tag, ".bus_we"}, 64'(bus_if.bus_we), 64'd0);
   endtask

   task automatic reset_in_wait();
      bit stale_done = 0;
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0200; core_wdata = 32'h5555_AAAA;
      @(negedge clk);
      core_req = 1'b0;
      bus_if.bus_gnt = 1'b1;
      @(negedge clk);
      bus_if.bus_gnt = 1'b0;
      check_eq("rst_wait.in_wait_stall", 64'(stall), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_wait");
      reset = 1'b0;
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = 32'hCAFE_F00D;
      for (int p = 0; p < 3; p++) begin
         @(negedge clk);
         if (core_done || stall) stale_done = 1;
      end
      bus_if.bus_rvalid = 1'b0;
      check_eq("rst_wait.stale_rvalid", 64'(stale_done), 64'd0);
      model_rdata = '0;
   endtask

   initial begin
      bus_if.bus_gnt    = 1'b0;
      bus_if.bus_rvalid = 1'b0;
      bus_if.bus_rdata  = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus_if.bus_rvalid = ($urandom_range(0, 1) == 1);
      end
      check_reset_outputs("reset");
      bus_if.bus_rvalid = 1'b0;
      reset = 1'b0;
      @(negedge clk);

      run_access(1'b0, 32'h0000_0100, 32'h0, 1, 2, 32'h00A0_0093, 0, "rd_basic");
      run_access(1'b1, 32'h0000_0104, 32'h1234_5678, 4, 5, 32'h0BAD_0BAD, 1, "wr_gnt_delay");
      run_access(1'b0, 32'h0000_0102, 32'h0, 1, 2, 32'h1111_1111, 0, "misaligned");
      run_access(1'b0, 32'h0000_0300, 32'h0, 1, 1000, 32'h2222_2222, 0, "timeout");
      run_access(1'b0, 32'h0000_0400, 32'h0, 1, 1, 32'hFFFF_FFFF, 0, "gnt_rvalid_same");
      run_access(1'b0, 32'h0000_0500, 32'h0, 3, TIMEOUT, 32'h3333_4444, 1, "rvalid_at_expiry");
      run_access(1'b0, 32'h0000_0600, 32'h0, TIMEOUT, TIMEOUT + 1, 32'h5555_6666, 1, "gnt_at_expiry");
      run_access(1'b1, 32'h0000_0700, 32'h7777_8888, TIMEOUT + 3, TIMEOUT + 3, 32'h0, 1, "gnt_never");
      reset_in_wait();

      for (int n = 0; n < 150; n++) begin
         logic [31:0] addr;
         int          kg;
         int          r;
         addr = $urandom;
         if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
         kg = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 4));
         r  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
         run_access(logic'($urandom_range(0, 1)), addr, $urandom, kg, kg + r, $urandom,
                    bit'($urandom_range(0, 1)), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

endmodule
